// File: rtl/score_pkg.sv
// score_keeper shared types: FSM states, BCD points table, BCD helpers.
// Optional feature macro used by the top: SCORE_BLINK_EN.
package score_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SAT,
        LINES
    } state_t;

    localparam int MAX_LEVEL = 9;

    // Points for 1..4 cleared rows, four BCD digits each (upper digits are 0).
    localparam logic [15:0] POINTS [4] = '{
        16'h0040,
        16'h0100,
        16'h0300,
        16'h1200
    };

    function automatic logic lines_ok(input logic [2:0] n);
        return (n >= 3'd1) && (n <= 3'd4);
    endfunction

    function automatic bcd_t pts_digit(input logic [2:0] n,
                                       input logic [1:0] d);
        logic [15:0] p;
        p = 16'h0000;
        case (n)
            3'd1:    p = POINTS[0];
            3'd2:    p = POINTS[1];
            3'd3:    p = POINTS[2];
            3'd4:    p = POINTS[3];
            default: p = 16'h0000;
        endcase
        return p[{d, 2'b00} +: 4];
    endfunction

    // One decimal digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_add(input bcd_t a,
                                           input bcd_t b,
                                           input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            s = s - 5'd10;
            return {1'b1, s[3:0]};
        end
        return {1'b0, s[3:0]};
    endfunction

endpackage

// File: rtl/bcd_seg7.sv
// score_keeper digit decoder: one BCD digit to active-low segments (gfedcba).
// Non-decimal codes blank the display.
module bcd_seg7
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Combinational segment lookup.
    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: BCD score/lines accumulator with digit-serial adder and level.
// Optional macro SCORE_BLINK_EN: blink the display while game_over is high.
module score_keeper
    import score_pkg::*;
#(
    parameter int NDIG      = 6,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_valid,
    input  logic [2:0]           clear_lines,
    output logic                 clear_ready,
    input  logic                 game_over,
    input  logic                 new_game,
    output logic [3:0]           level,
    output logic                 busy,
    output logic [NDIG-1:0][6:0] hex
);

    localparam int DW = (NDIG > 4) ? $clog2(NDIG) : 2;

    state_t        state_q, state_d;
    bcd_t          score     [NDIG];
    bcd_t          score_upd [NDIG];
    bcd_t          disp      [NDIG];
    bcd_t          lines     [3];
    bcd_t          lines_new [3];
    logic [2:0]    lat_n;
    logic [3:0]    pass_cnt;
    logic [DW-1:0] dig;
    logic          carry;
    logic          accept;
    logic          last;
    bcd_t          pd;
    bcd_t          add_s;
    logic          add_c;
    logic [3:0]    level_new;
    logic [NDIG-1:0][6:0] seg;

    assign clear_ready = (state_q == IDLE) && !game_over;
    assign busy        = (state_q != IDLE);
    assign accept      = clear_valid && clear_ready;
    assign last        = (dig == DW'(NDIG - 1));

    // Current digit of the adder and the score with that digit replaced.
    always_comb begin
        pd = 4'h0;
        if (int'(dig) < 4) pd = pts_digit(lat_n, dig[1:0]);
        {add_c, add_s} = bcd_add(score[dig], pd, carry);
        for (int i = 0; i < NDIG; i++) begin
            score_upd[i] = (DW'(i) == dig) ? add_s : score[i];
        end
    end

    // Lines counter increment with saturation at 999, and derived level.
    always_comb begin
        logic [4:0] r0, r1, r2;
        r0 = bcd_add(lines[0], {1'b0, lat_n}, 1'b0);
        r1 = bcd_add(lines[1], 4'h0, r0[4]);
        r2 = bcd_add(lines[2], 4'h0, r1[4]);
        lines_new[0] = r0[3:0];
        lines_new[1] = r1[3:0];
        lines_new[2] = r2[3:0];
        if (r2[4]) begin
            lines_new[0] = 4'h9;
            lines_new[1] = 4'h9;
            lines_new[2] = 4'h9;
        end
        level_new = (lines_new[2] != 4'h0) ? 4'(MAX_LEVEL) : lines_new[1];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; new_game overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = LOAD;
            LOAD:  state_d = lines_ok(lat_n) ? ADD : IDLE;
            ADD: begin
                if (last) begin
                    if (add_c)                 state_d = SAT;
                    else if (pass_cnt != 4'd0) state_d = ADD;
                    else                       state_d = LINES;
                end
            end
            SAT:     state_d = LINES;
            LINES:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    // Score, lines, level and display datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score    <= '{default: 4'h0};
            disp     <= '{default: 4'h0};
            lines    <= '{default: 4'h0};
            level    <= 4'd0;
            lat_n    <= 3'd0;
            pass_cnt <= 4'd0;
            dig      <= '0;
            carry    <= 1'b0;
        end else if (new_game) begin
            score    <= '{default: 4'h0};
            disp     <= '{default: 4'h0};
            lines    <= '{default: 4'h0};
            level    <= 4'd0;
            lat_n    <= 3'd0;
            pass_cnt <= 4'd0;
            dig      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) lat_n <= clear_lines;
                LOAD: begin
                    pass_cnt <= level;
                    dig      <= '0;
                    carry    <= 1'b0;
                end
                ADD: begin
                    score <= score_upd;
                    if (last) begin
                        dig   <= '0;
                        carry <= 1'b0;
                        if (!add_c) begin
                            if (pass_cnt != 4'd0) pass_cnt <= pass_cnt - 4'd1;
                            else                  disp     <= score_upd;
                        end
                    end else begin
                        dig   <= dig + DW'(1);
                        carry <= add_c;
                    end
                end
                SAT: begin
                    score <= '{default: 4'h9};
                    disp  <= '{default: 4'h9};
                end
                LINES: begin
                    lines <= lines_new;
                    level <= level_new;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_seg
        bcd_seg7 u_seg (
            .digit (disp[g]),
            .seg   (seg[g])
        );
    end

`ifdef SCORE_BLINK_EN
    logic [31:0] blink_cnt;
    logic        blink_off;

    // Half-period counter; restarts with score visible when game_over drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= 32'd0;
            blink_off <= 1'b0;
        end else if (!game_over) begin
            blink_cnt <= 32'd0;
            blink_off <= 1'b0;
        end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
            blink_cnt <= 32'd0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign hex = blink_off ? {NDIG{7'h7F}} : seg;
`else
    assign hex = seg;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: latency, level scaling, saturation,
// handshake, new_game and game_over behaviour against a small integer model.
module tb_score_keeper;

    logic            clk;
    logic            reset_n;
    logic            clear_valid;
    logic [2:0]      clear_lines;
    logic            clear_ready;
    logic            game_over;
    logic            new_game;
    logic [3:0]      level;
    logic            busy;
    logic [5:0][6:0] hex;

    int vectors = 0;
    int fails   = 0;
    int m_score = 0;
    int m_lines = 0;
    int m_level = 0;

    score_keeper #(
        .NDIG      (6),
        .BLINK_DIV (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_valid (clear_valid),
        .clear_lines (clear_lines),
        .clear_ready (clear_ready),
        .game_over   (game_over),
        .new_game    (new_game),
        .level       (level),
        .busy        (busy),
        .hex         (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [5:0][6:0] exp_hex(input int s);
        logic [5:0][6:0] h;
        int v;
        v = s;
        for (int i = 0; i < 6; i++) begin
            h[i] = seg_of(v % 10);
            v = v / 10;
        end
        return h;
    endfunction

    function automatic int pts_of(input int n);
        case (n)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return 1200;
            default: return 0;
        endcase
    endfunction

    task automatic model_event(input int n);
        if (n >= 1 && n <= 4) begin
            m_score = m_score + pts_of(n) * (m_level + 1);
            if (m_score > 999999) m_score = 999999;
            m_lines = m_lines + n;
            if (m_lines > 999) m_lines = 999;
            m_level = (m_lines / 10 > 9) ? 9 : m_lines / 10;
        end
    endtask

    // Offer one event, wait for it to finish, compare display and level.
    task automatic run_event(input int n, input string tag);
        int   waitc;
        logic bad;
        clear_lines = 3'(n);
        clear_valid = 1'b1;
        waitc = 0;
        while (clear_ready !== 1'b1 && waitc < 200) begin
            tick;
            waitc++;
        end
        vectors++;
        if (clear_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept_wait: clear_ready=%b required 1", tag, clear_ready);
        end
        tick;
        clear_valid = 1'b0;
        clear_lines = 3'd0;
        bad = 1'b0;
        waitc = 0;
        while (busy === 1'b1 && waitc < 200) begin
            if (clear_ready !== 1'b0) bad = 1'b1;
            tick;
            waitc++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_timeout: busy=%b required 0", tag, busy);
        end
        vectors++;
        if (bad) begin
            fails++;
            $display("FAIL %s ready_in_busy: clear_ready=1 required 0", tag);
        end
        model_event(n);
        vectors++;
        if (hex !== exp_hex(m_score)) begin
            fails++;
            $display("FAIL %s hex: got %h required %h", tag, hex, exp_hex(m_score));
        end
        vectors++;
        if (level !== 4'(m_level)) begin
            fails++;
            $display("FAIL %s level: got %0d required %0d", tag, level, m_level);
        end
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        clear_valid = 1'b0;
        clear_lines = 3'd0;
        game_over   = 1'b0;
        new_game    = 1'b0;
        tick;
        tick;
        vectors++;
        if (hex !== {6{7'h40}}) begin
            fails++;
            $display("FAIL reset_hex: got %h required %h", hex, {6{7'h40}});
        end
        vectors++;
        if (level !== 4'd0) begin
            fails++;
            $display("FAIL reset_level: got %0d required 0", level);
        end
        vectors++;
        if (clear_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b required 1", clear_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
        reset_n = 1'b1;
        tick;
    endtask

    // Level 0 tetris: score appears exactly 7 cycles after accept.
    task automatic test_tetris_latency;
        clear_lines = 3'd4;
        clear_valid = 1'b1;
        tick;
        clear_valid = 1'b0;
        for (int k = 1; k <= 6; k++) tick;
        vectors++;
        if (hex !== exp_hex(0)) begin
            fails++;
            $display("FAIL tetris_early: got %h required %h", hex, exp_hex(0));
        end
        tick;
        vectors++;
        if (hex !== exp_hex(1200)) begin
            fails++;
            $display("FAIL tetris_at7: got %h required %h", hex, exp_hex(1200));
        end
        vectors++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL tetris_busy7: got %b required 1", busy);
        end
        tick;
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL tetris_done: busy=%b required 0", busy);
        end
        model_event(4);
    endtask

    // Reach level 1, then a double must take 1+12 cycles and add 200.
    task automatic test_level_up;
        run_event(4, "lvl_a");
        run_event(2, "lvl_b");
        clear_lines = 3'd2;
        clear_valid = 1'b1;
        tick;
        clear_valid = 1'b0;
        for (int k = 1; k <= 12; k++) tick;
        vectors++;
        if (hex !== exp_hex(m_score)) begin
            fails++;
            $display("FAIL lvl_early: got %h required %h", hex, exp_hex(m_score));
        end
        tick;
        model_event(2);
        vectors++;
        if (hex !== exp_hex(m_score)) begin
            fails++;
            $display("FAIL lvl_at13: got %h required %h", hex, exp_hex(m_score));
        end
        tick;
        vectors++;
        if (level !== 4'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL lvl_after: level=%0d busy=%b required 1 0", level, busy);
        end
    endtask

    task automatic test_ignored;
        run_event(0, "ign0");
        run_event(5, "ign5");
        run_event(7, "ign7");
    endtask

    // Event held valid during busy must wait for IDLE.
    task automatic test_back_to_back;
        int   waitc;
        logic bad;
        clear_lines = 3'd1;
        clear_valid = 1'b1;
        tick;
        clear_lines = 3'd3;
        bad = 1'b0;
        waitc = 0;
        while (busy === 1'b1 && waitc < 200) begin
            if (clear_ready !== 1'b0) bad = 1'b1;
            tick;
            waitc++;
        end
        model_event(1);
        vectors++;
        if (bad || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_hold: bad=%b busy=%b required 0 0", bad, busy);
        end
        vectors++;
        if (hex !== exp_hex(m_score)) begin
            fails++;
            $display("FAIL b2b_first: got %h required %h", hex, exp_hex(m_score));
        end
        tick;
        clear_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_accept: busy=%b required 1", busy);
        end
        waitc = 0;
        while (busy === 1'b1 && waitc < 200) begin
            tick;
            waitc++;
        end
        model_event(3);
        vectors++;
        if (hex !== exp_hex(m_score) || level !== 4'(m_level)) begin
            fails++;
            $display("FAIL b2b_second: hex %h level %0d required %h %0d",
                     hex, level, exp_hex(m_score), m_level);
        end
    endtask

    task automatic test_game_over;
        int waitc;
        clear_lines = 3'd4;
        clear_valid = 1'b1;
        tick;
        clear_valid = 1'b0;
        tick;
        tick;
        game_over = 1'b1;
        waitc = 0;
        while (busy === 1'b1 && waitc < 200) begin
            tick;
            waitc++;
        end
        model_event(4);
        vectors++;
        if (hex !== exp_hex(m_score)) begin
            fails++;
            $display("FAIL go_complete: got %h required %h", hex, exp_hex(m_score));
        end
        vectors++;
        if (clear_ready !== 1'b0) begin
            fails++;
            $display("FAIL go_ready: got %b required 0", clear_ready);
        end
        game_over   = 1'b0;
        tick;
        game_over   = 1'b1;
        clear_lines = 3'd1;
        clear_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            vectors++;
            if (busy !== 1'b0 || clear_ready !== 1'b0) begin
                fails++;
                $display("FAIL go_block_%0d: busy=%b ready=%b required 0 0", k, busy, clear_ready);
            end
`ifdef SCORE_BLINK_EN
            vectors++;
            if ((k >= 4 && k < 8) ? (hex !== {6{7'h7F}}) : (hex !== exp_hex(m_score))) begin
                fails++;
                $display("FAIL blink_%0d: got %h", k, hex);
            end
`else
            vectors++;
            if (hex !== exp_hex(m_score)) begin
                fails++;
                $display("FAIL go_hex_%0d: got %h required %h", k, hex, exp_hex(m_score));
            end
`endif
        end
        clear_valid = 1'b0;
        game_over   = 1'b0;
        tick;
        vectors++;
        if (hex !== exp_hex(m_score) || clear_ready !== 1'b1) begin
            fails++;
            $display("FAIL go_release: hex %h ready %b required %h 1", hex, clear_ready, exp_hex(m_score));
        end
    endtask

    task automatic test_new_game;
        clear_lines = 3'd3;
        clear_valid = 1'b1;
        tick;
        clear_valid = 1'b0;
        tick;
        tick;
        tick;
        new_game = 1'b1;
        tick;
        new_game = 1'b0;
        m_score = 0;
        m_lines = 0;
        m_level = 0;
        vectors++;
        if (hex !== exp_hex(0) || level !== 4'd0 || busy !== 1'b0 || clear_ready !== 1'b1) begin
            fails++;
            $display("FAIL ng_abort: hex %h level %0d busy %b ready %b required %h 0 0 1",
                     hex, level, busy, clear_ready, exp_hex(0));
        end
        clear_lines = 3'd4;
        clear_valid = 1'b1;
        new_game    = 1'b1;
        tick;
        clear_valid = 1'b0;
        new_game    = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ng_drop: busy=%b required 0", busy);
        end
        for (int k = 0; k < 10; k++) tick;
        vectors++;
        if (hex !== exp_hex(0)) begin
            fails++;
            $display("FAIL ng_drop_hex: got %h required %h", hex, exp_hex(0));
        end
    endtask

    // Tetrises until the score pins at 999999, then one more event.
    task automatic test_saturate;
        int guard;
        guard = 0;
        while (m_score < 999999 && guard < 300) begin
            run_event(4, "sat_fill");
            guard++;
        end
        vectors++;
        if (m_score != 999999 || level !== 4'd9) begin
            fails++;
            $display("FAIL sat_reach: model %0d level %0d required 999999 9", m_score, level);
        end
        run_event(1, "sat_extra");
        run_event(4, "sat_extra4");
    endtask

    initial begin
        test_reset;
        test_tetris_latency;
        test_level_up;
        test_ignored;
        test_back_to_back;
        test_game_over;
        test_new_game;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
